// File: rtl/ff_exerciser_if.sv
// Pin bundle between the flip-flop exerciser (master) and the D flip-flop under test (slave).
interface ff_exerciser_if;
  logic dut_d;
  logic dut_s_n;
  logic dut_r_n;
  logic dut_q;
  logic dut_qb;

  modport master (
    output dut_d, dut_s_n, dut_r_n,
    input  dut_q, dut_qb
  );

  modport slave (
    input  dut_d, dut_s_n, dut_r_n,
    output dut_q, dut_qb
  );
endinterface

// File: rtl/ff_exerciser.sv
// Stimulus/response engine for a falling-edge D flip-flop with async set/reset.
// Optional macro FF_EXER_FIRST_ERR_EN adds first-failure capture outputs.
module ff_exerciser #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int unsigned ERR_W       = 8,
  localparam int unsigned VEC_W      = $clog2(NUM_VECTORS + 1)
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  ff_exerciser_if.master    ff,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [VEC_W-1:0]  vec_count
`ifdef FF_EXER_FIRST_ERR_EN
  ,
  output logic              first_err_valid,
  output logic [1:0]        first_err_phase,
  output logic [VEC_W-1:0]  first_err_idx
`endif
);

  localparam logic [7:0]       SeedEff = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [VEC_W-1:0] LastVec = VEC_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {StIdle, StSet, StReset, StData, StDone} state_e;

  state_e           state_q;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic             chk_active;
  logic             chk_fail;
  logic [ERR_W-1:0] err_d;
  logic             run_start;

  // In every checked phase the expected Q equals the D driven that cycle.
  always_comb begin
    chk_active = (state_q == StSet) || (state_q == StReset) || (state_q == StData);
    chk_fail   = chk_active && ((ff.dut_q != ff.dut_d) || (ff.dut_qb == ff.dut_d));
    err_d      = err_count;
    if (chk_fail && (err_count != {ERR_W{1'b1}})) begin
      err_d = err_count + 1'b1;
    end
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    run_start = ((state_q == StIdle) || (state_q == StDone)) && start;
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      state_q    <= StIdle;
      ff.dut_d   <= 1'b0;
      ff.dut_s_n <= 1'b1;
      ff.dut_r_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_count  <= '0;
      lfsr_q     <= SeedEff;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StSet;
            ff.dut_d   <= 1'b1;
            ff.dut_s_n <= 1'b0;
            ff.dut_r_n <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            lfsr_q     <= SeedEff;
          end
        end
        StSet: begin
          err_count  <= err_d;
          state_q    <= StReset;
          ff.dut_d   <= 1'b0;
          ff.dut_s_n <= 1'b1;
          ff.dut_r_n <= 1'b0;
        end
        StReset: begin
          err_count  <= err_d;
          state_q    <= StData;
          ff.dut_d   <= lfsr_q[0];
          ff.dut_r_n <= 1'b1;
        end
        StData: begin
          err_count <= err_d;
          lfsr_q    <= lfsr_d;
          vec_count <= vec_count + 1'b1;
          if (vec_count == LastVec) begin
            state_q  <= StDone;
            ff.dut_d <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (err_d == '0);
          end else begin
            ff.dut_d <= lfsr_d[0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FF_EXER_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (!R || run_start) begin
      first_err_valid <= 1'b0;
      first_err_phase <= 2'd0;
      first_err_idx   <= '0;
    end else if (chk_fail && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_idx   <= vec_count;
      unique case (state_q)
        StSet:   first_err_phase <= 2'd0;
        StReset: first_err_phase <= 2'd1;
        default: first_err_phase <= 2'd2;
      endcase
    end
  end
`else
  logic unused_run_start;
  assign unused_run_start = run_start;
`endif

endmodule

// File: tb/tb_ff_exerciser.sv
// Scoreboard bench for ff_exerciser driving behavioural falling-edge flip-flop models.
module tb_ff_exerciser;
  localparam int unsigned NV = 16;
  localparam int unsigned VW = $clog2(NV + 1);
  // dut_d over the 16 DATA vectors from seed A5, vector 0 in bit 0
  localparam logic [15:0] DPAT = 16'h6EE5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       R;
  logic       start;
  logic [1:0] mode;  // 0 ideal, 1 Qb tied to Q, 2 Q stuck low

  ff_exerciser_if ffa ();
  ff_exerciser_if ffb ();

  logic          busy, done, pass;
  logic [7:0]    err;
  logic [VW-1:0] vec;
  logic          busy4, done4, pass4;
  logic [3:0]    err4;
  logic [VW-1:0] vec4;
`ifdef FF_EXER_FIRST_ERR_EN
  logic          fe_valid, fe_valid4;
  logic [1:0]    fe_phase, fe_phase4;
  logic [VW-1:0] fe_idx, fe_idx4;
`endif

  ff_exerciser #(.NUM_VECTORS(NV), .SEED(8'hA5), .ERR_W(8)) dut (
    .clk(clk), .R(R), .start(start), .ff(ffa),
    .busy(busy), .done(done), .pass(pass), .err_count(err), .vec_count(vec)
`ifdef FF_EXER_FIRST_ERR_EN
    , .first_err_valid(fe_valid), .first_err_phase(fe_phase), .first_err_idx(fe_idx)
`endif
  );

  ff_exerciser #(.NUM_VECTORS(NV), .SEED(8'hA5), .ERR_W(4)) dut4 (
    .clk(clk), .R(R), .start(start), .ff(ffb),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .vec_count(vec4)
`ifdef FF_EXER_FIRST_ERR_EN
    , .first_err_valid(fe_valid4), .first_err_phase(fe_phase4), .first_err_idx(fe_idx4)
`endif
  );

  // Falling-edge DFF models with async active-low set/reset
  logic qa = 1'b0;
  logic qb = 1'b0;
  always @(negedge clk or negedge ffa.dut_s_n or negedge ffa.dut_r_n)
    if (!ffa.dut_s_n) qa <= 1'b1;
    else if (!ffa.dut_r_n) qa <= 1'b0;
    else qa <= ffa.dut_d;
  always @(negedge clk or negedge ffb.dut_s_n or negedge ffb.dut_r_n)
    if (!ffb.dut_s_n) qb <= 1'b1;
    else if (!ffb.dut_r_n) qb <= 1'b0;
    else qb <= ffb.dut_d;

  assign ffa.dut_q  = (mode == 2'd2) ? 1'b0 : qa;
  assign ffa.dut_qb = (mode == 2'd1) ? ffa.dut_q : ~ffa.dut_q;
  assign ffb.dut_q  = qb;
  assign ffb.dut_qb = qb;  // always miswired: every check fails

  typedef struct {
    int          err;
    bit          pass;
    int          vec;
    int          blen;
    logic [15:0] dpat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push_exp(input int e, input bit p);
    exp_t x;
    x.err  = e;
    x.pass = p;
    x.vec  = NV;
    x.blen = NV + 2;
    x.dpat = DPAT;
    exp_q.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Monitor: accumulate each run, compare against the scoreboard when done rises
  initial begin
    int          busy_len = 0;
    int          dcnt = 0;
    logic [15:0] dcap = '0;
    logic        done_prev = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (busy) begin
        busy_len++;
        if (ffa.dut_s_n && ffa.dut_r_n) begin
          if (dcnt < 16) dcap[dcnt[3:0]] = ffa.dut_d;
          dcnt++;
        end
      end else begin
        if (done && !done_prev) begin
          chk("sb_underflow", 32'(exp_q.size() == 0), 32'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("run_err_count", 32'(err), 32'(e.err));
            chk("run_pass", 32'(pass), 32'(e.pass));
            chk("run_vec_count", 32'(vec), 32'(e.vec));
            chk("run_busy_len", 32'(busy_len), 32'(e.blen));
            chk("run_d_seq", 32'(dcap), 32'(e.dpat));
          end
        end
        busy_len = 0;
        dcnt     = 0;
        dcap     = '0;
      end
      done_prev = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    R     = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'({busy, done, pass, ffa.dut_s_n, ffa.dut_r_n, ffa.dut_d}),
        32'b000110);
    chk("reset_counts", 32'({err, vec}), 32'd0);
    R = 1'b1;
    @(negedge clk);

    // Clean run with ideal flip-flop
    push_exp(0, 1'b1);
    pulse_start();
    wait_done("t1_done");
    repeat (3) @(negedge clk);
    chk("t1_done_sticky", 32'({done, pass, busy}), 32'b110);

    // Qb miswired: all 18 checks fail; 4-bit counter saturates
    mode = 2'd1;
    push_exp(18, 1'b0);
    pulse_start();
    wait_done("t2_done");
    chk("t3_err4_sat", 32'(err4), 32'd15);
    chk("t3_done4", 32'({done4, pass4}), 32'b10);

    // Reset in the middle of a run
    mode = 2'd0;
    pulse_start();
    n = 0;
    while (vec != VW'(5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_vec5", 32'(vec), 32'd5);
    R = 1'b0;
    @(negedge clk);
    chk("t4_abort_ctrl", 32'({busy, done, pass, ffa.dut_s_n, ffa.dut_r_n, ffa.dut_d}),
        32'b000110);
    chk("t4_abort_counts", 32'({err, vec}), 32'd0);
    R = 1'b1;
    push_exp(0, 1'b1);
    pulse_start();
    wait_done("t4_done");

    // start held: back-to-back runs separated by one DONE cycle
    push_exp(0, 1'b1);
    push_exp(0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    wait_done("t5_done_a");
    @(negedge clk);
    chk("t5_gap", 32'({done, busy}), 32'b01);
    wait_done("t5_done_b");
    start = 1'b0;
    @(negedge clk);
    chk("t5_sticky", 32'({done, busy}), 32'b10);

    // Q stuck low: SET fails, RESET passes, DATA fails on the 10 ones of DPAT
    mode = 2'd2;
    push_exp(11, 1'b0);
    pulse_start();
    wait_done("t6_done");
`ifdef FF_EXER_FIRST_ERR_EN
    chk("t6_fe_valid", 32'(fe_valid), 32'd1);
    chk("t6_fe_phase", 32'(fe_phase), 32'd0);
    chk("t6_fe_idx", 32'(fe_idx), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_exerciser.md
Name: ff_exerciser

Overview:
Self-checking stimulus/response engine for the edge-triggered D flip-flop with active-low asynchronous set/reset (D, S, R, clk, Q, Qb) used throughout the design. It drives the flip-flop's inputs, samples Q/Qb, and counts mismatches against an internal expected model. It is the initiator side of that flip-flop interface and is instantiated next to the flip-flop under test for built-in self-test and bench regression.

Parameters:
NUM_VECTORS, 16, number of pseudo-random data vectors applied in the DATA phase (>=1)
SEED, 8'hA5, LFSR seed; a value of 0 is replaced by 8'h01
ERR_W, 8, width of err_count

Ports:
clk  input  1  system clock; engine logic updates on the rising edge
R  input  1  synchronous active-low reset
start  input  1  begin a test run; sampled only in IDLE or DONE
dut_q  input  1  Q from the flip-flop under test
dut_qb  input  1  Qb from the flip-flop under test
dut_d  output  1  D drive to the flip-flop under test
dut_s_n  output  1  active-low set drive to the flip-flop under test
dut_r_n  output  1  active-low reset drive to the flip-flop under test
busy  output  1  high while a run is in progress
done  output  1  high in DONE, sticky until the next start or reset
pass  output  1  valid while done=1: 1 if err_count==0
err_count  output  ERR_W  mismatch count, saturating at 2^ERR_W-1
vec_count  output  $clog2(NUM_VECTORS+1)  number of data vectors applied so far

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (R sampled low at a clk rising edge).
- Reset values: state=IDLE, dut_d=0, dut_s_n=1, dut_r_n=1, busy=0, done=0, pass=0, err_count=0, vec_count=0, lfsr=SEED.
- Reset mid-run: the engine returns to IDLE on the next edge, DUT drives go to their idle values, and all counters clear.
- Timing model: the engine drives outputs on the rising edge. The DUT captures D on the following falling edge. The engine checks the DUT at the next rising edge, so each check covers the drive applied one cycle earlier.
- States:
  - IDLE: busy=0. On start=1, go to SET_PULSE; clear done, pass, err_count, and vec_count; reload lfsr=SEED; busy=1.
  - SET_PULSE (1 cycle): dut_s_n=0, dut_r_n=1, dut_d=1. At exit, check dut_q==1 and dut_qb==0. Go to RESET_PULSE.
  - RESET_PULSE (1 cycle): dut_s_n=1, dut_r_n=0, dut_d=0. At exit, check dut_q==0 and dut_qb==1. Go to DATA.
  - DATA (NUM_VECTORS cycles): dut_s_n=dut_r_n=1 and dut_d=lfsr[0].
    - At each exit, check dut_q==exp and dut_qb==~exp, where exp is the dut_d driven during that cycle.
    - Then shift the lfsr and increment vec_count.
    - After the vector with vec_count==NUM_VECTORS, go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0); DUT drives at idle values. On start=1, behave exactly as IDLE+start.
- Error counting: at most one increment per check. A check fails if either Q or Qb is wrong. err_count saturates and never wraps.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0. It advances only in DATA.
- start: ignored while busy=1.
- Run length: busy is high for exactly 2+NUM_VECTORS cycles.

Optional Feature:
FF_EXER_FIRST_ERR_EN
- Defined:
  - Adds outputs first_err_valid (1 bit), first_err_phase (2 bits: 0=SET, 1=RESET, 2=DATA), and first_err_idx (vec_count width).
  - These latch on the first failing check of a run.
  - They clear on start or reset and hold until then.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Ideal falling-edge DFF model connected; R=0 for 2 cycles, then start pulse -> busy high for 18 cycles, then done=1, pass=1, err_count=0, vec_count=16.
2. dut_qb wired to dut_q (Qb wrong on every check) -> err_count=18, pass=0, done=1.
3. ERR_W=4 with the same miswiring as test 2 -> err_count saturates at 15 and does not wrap.
4. Ideal DUT; R=0 for one cycle at vec_count=5 -> next cycle state=IDLE, busy=0, dut_s_n=dut_r_n=1, dut_d=0, err_count=0. A following start runs a full clean 18-cycle pass.
5. start held high continuously -> back-to-back runs with exactly one DONE cycle between them (done=1 for 1 cycle); the dut_d sequence repeats identically each run.
6. With FF_EXER_FIRST_ERR_EN, dut_q stuck at 0 and dut_qb=~dut_q -> first_err_valid=1, first_err_phase=0 (SET), first_err_idx=0, pass=0.
